// File: rtl/dec_sched.sv
// ---------------------------------------------------------------------------
// dec_sched -- frame scheduler for the RS decoder.
//
// Received symbols are written into a two-bank (ping-pong) codeword buffer.
// Each bank then moves, strictly in frame order, through key-equation solving
// (KES/Chien) and correction/output before it is released for the next frame.
// The scheduler owns input back-pressure and the start handshakes of the
// downstream KES and correction stages.
//
// Bank life cycle: EMPTY -> FILL -> WAIT_KES -> KES -> WAIT_COR -> COR -> EMPTY
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid/in_sop/in_data  input symbol stream (in_sop marks index 0)
//   in_ready               symbol can be accepted this cycle
//   buf_wr/buf_waddr/buf_wdata  registered buffer write port, addr = {bank, index}
//   kes_start/kes_bank/kes_done  KES job handshake (start pulse, bank held, done pulse)
//   cor_start/cor_bank/cor_done  correction job handshake
//   sop_err                pulse: in_sop at a bad position (or missing)
//   proto_err              sticky: done pulse with no job active
// ---------------------------------------------------------------------------
module dec_sched #(
  parameter int SYM_BW = 8,
  parameter int N_NUM  = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              in_sop,
  input  logic [SYM_BW-1:0] in_data,
  output logic              in_ready,
  output logic              buf_wr,
  output logic [8:0]        buf_waddr,
  output logic [SYM_BW-1:0] buf_wdata,
  output logic              kes_start,
  output logic              kes_bank,
  input  logic              kes_done,
  output logic              cor_start,
  output logic              cor_bank,
  input  logic              cor_done,
  output logic              sop_err,
  output logic              proto_err
);

  typedef enum logic [2:0] {
    B_EMPTY    = 3'd0,
    B_FILL     = 3'd1,
    B_WAIT_KES = 3'd2,
    B_KES      = 3'd3,
    B_WAIT_COR = 3'd4,
    B_COR      = 3'd5
  } bank_st_e;

  localparam logic [7:0] LAST_IDX = 8'(N_NUM - 1);

  // Per-bank state and stage pointers
  bank_st_e st_q [2];
  bank_st_e st_d [2];
  logic     wr_ptr_q,  wr_ptr_d;
  logic     kes_ptr_q, kes_ptr_d;
  logic     cor_ptr_q, cor_ptr_d;
  logic [7:0] wr_cnt_q, wr_cnt_d;
  logic     kes_act_q, kes_act_d;
  logic     cor_act_q, cor_act_d;
  logic     kes_bank_q, kes_bank_d;
  logic     cor_bank_q, cor_bank_d;
  logic     proto_err_q, proto_err_d;

  // Output register stage (one cycle behind the accept / issue decision)
  logic              buf_wr_p1,    buf_wr_d;
  logic [8:0]        buf_waddr_p1, buf_waddr_d;
  logic [SYM_BW-1:0] buf_wdata_p1, buf_wdata_d;
  logic              kes_start_p1, kes_start_d;
  logic              cor_start_p1, cor_start_d;
  logic              sop_err_p1,   sop_err_d;

  logic accept;

  // Ready is decoded from registered bank state only, so there is no
  // combinational path from in_valid back to in_ready.
  assign in_ready = (st_q[wr_ptr_q] == B_EMPTY) || (st_q[wr_ptr_q] == B_FILL);
  assign accept   = in_valid & in_ready;

  // Next-state logic. Every bank transition below is guarded by a distinct
  // current state (EMPTY/FILL, WAIT_KES, KES, WAIT_COR, COR), so at most one
  // of them can touch a given bank in any cycle and simultaneous events on
  // different banks/stages all take effect.
  always_comb begin
    st_d[0]     = st_q[0];
    st_d[1]     = st_q[1];
    wr_ptr_d    = wr_ptr_q;
    kes_ptr_d   = kes_ptr_q;
    cor_ptr_d   = cor_ptr_q;
    wr_cnt_d    = wr_cnt_q;
    kes_act_d   = kes_act_q;
    cor_act_d   = cor_act_q;
    kes_bank_d  = kes_bank_q;
    cor_bank_d  = cor_bank_q;
    proto_err_d = proto_err_q;
    buf_wr_d    = 1'b0;
    buf_waddr_d = buf_waddr_p1;
    buf_wdata_d = buf_wdata_p1;
    kes_start_d = 1'b0;
    cor_start_d = 1'b0;
    sop_err_d   = 1'b0;

    // Fill side
    if (accept) begin
      if (st_q[wr_ptr_q] == B_EMPTY) begin
        if (in_sop) begin
          st_d[wr_ptr_q] = B_FILL;
          buf_wr_d       = 1'b1;
          buf_waddr_d    = {wr_ptr_q, 8'd0};
          buf_wdata_d    = in_data;
          wr_cnt_d       = 8'd1;
        end else begin
          // Mid-frame symbol with no frame open: drop it.
          sop_err_d = 1'b1;
        end
      end else begin
        buf_wr_d    = 1'b1;
        buf_wdata_d = in_data;
        if (in_sop) begin
          // Early sop: abandon the partial frame and restart at index 0.
          sop_err_d   = 1'b1;
          buf_waddr_d = {wr_ptr_q, 8'd0};
          wr_cnt_d    = 8'd1;
        end else begin
          buf_waddr_d = {wr_ptr_q, wr_cnt_q};
          if (wr_cnt_q == LAST_IDX) begin
            st_d[wr_ptr_q] = B_WAIT_KES;
            wr_ptr_d       = ~wr_ptr_q;
            wr_cnt_d       = 8'd0;
          end else begin
            wr_cnt_d = wr_cnt_q + 8'd1;
          end
        end
      end
    end

    // KES stage: issue and completion are mutually exclusive via kes_act_q
    if (!kes_act_q && (st_q[kes_ptr_q] == B_WAIT_KES)) begin
      st_d[kes_ptr_q] = B_KES;
      kes_start_d     = 1'b1;
      kes_bank_d      = kes_ptr_q;
      kes_act_d       = 1'b1;
    end
    if (kes_done) begin
      if (kes_act_q) begin
        st_d[kes_bank_q] = B_WAIT_COR;
        kes_ptr_d        = ~kes_ptr_q;
        kes_act_d        = 1'b0;
      end else begin
        proto_err_d = 1'b1;
      end
    end

    // Correction stage
    if (!cor_act_q && (st_q[cor_ptr_q] == B_WAIT_COR)) begin
      st_d[cor_ptr_q] = B_COR;
      cor_start_d     = 1'b1;
      cor_bank_d      = cor_ptr_q;
      cor_act_d       = 1'b1;
    end
    if (cor_done) begin
      if (cor_act_q) begin
        st_d[cor_bank_q] = B_EMPTY;
        cor_ptr_d        = ~cor_ptr_q;
        cor_act_d        = 1'b0;
      end else begin
        proto_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q[0]      <= B_EMPTY;
      st_q[1]      <= B_EMPTY;
      wr_ptr_q     <= 1'b0;
      kes_ptr_q    <= 1'b0;
      cor_ptr_q    <= 1'b0;
      wr_cnt_q     <= 8'd0;
      kes_act_q    <= 1'b0;
      cor_act_q    <= 1'b0;
      kes_bank_q   <= 1'b0;
      cor_bank_q   <= 1'b0;
      proto_err_q  <= 1'b0;
      buf_wr_p1    <= 1'b0;
      buf_waddr_p1 <= 9'd0;
      buf_wdata_p1 <= '0;
      kes_start_p1 <= 1'b0;
      cor_start_p1 <= 1'b0;
      sop_err_p1   <= 1'b0;
    end else begin
      st_q[0]      <= st_d[0];
      st_q[1]      <= st_d[1];
      wr_ptr_q     <= wr_ptr_d;
      kes_ptr_q    <= kes_ptr_d;
      cor_ptr_q    <= cor_ptr_d;
      wr_cnt_q     <= wr_cnt_d;
      kes_act_q    <= kes_act_d;
      cor_act_q    <= cor_act_d;
      kes_bank_q   <= kes_bank_d;
      cor_bank_q   <= cor_bank_d;
      proto_err_q  <= proto_err_d;
      // ---- stage p1: registered write port and start/error pulses ----
      buf_wr_p1    <= buf_wr_d;
      buf_waddr_p1 <= buf_waddr_d;
      buf_wdata_p1 <= buf_wdata_d;
      kes_start_p1 <= kes_start_d;
      cor_start_p1 <= cor_start_d;
      sop_err_p1   <= sop_err_d;
    end
  end

  assign buf_wr    = buf_wr_p1;
  assign buf_waddr = buf_waddr_p1;
  assign buf_wdata = buf_wdata_p1;
  assign kes_start = kes_start_p1;
  assign kes_bank  = kes_bank_q;
  assign cor_start = cor_start_p1;
  assign cor_bank  = cor_bank_q;
  assign sop_err   = sop_err_p1;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_dec_sched.sv
// ---------------------------------------------------------------------------
// tb_dec_sched -- directed self-checking bench for dec_sched (SYM_BW=8,
// N_NUM=255). Inputs change 1 ns after the rising edge; a negedge monitor
// records buffer writes and start/error pulses for the tests to inspect.
// ---------------------------------------------------------------------------
module tb_dec_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_sop = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       in_ready;
  logic       buf_wr;
  logic [8:0] buf_waddr;
  logic [7:0] buf_wdata;
  logic       kes_start;
  logic       kes_bank;
  logic       kes_done = 1'b0;
  logic       cor_start;
  logic       cor_bank;
  logic       cor_done = 1'b0;
  logic       sop_err;
  logic       proto_err;

  dec_sched #(.SYM_BW(8), .N_NUM(255)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_sop(in_sop), .in_data(in_data), .in_ready(in_ready),
    .buf_wr(buf_wr), .buf_waddr(buf_waddr), .buf_wdata(buf_wdata),
    .kes_start(kes_start), .kes_bank(kes_bank), .kes_done(kes_done),
    .cor_start(cor_start), .cor_bank(cor_bank), .cor_done(cor_done),
    .sop_err(sop_err), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int stall_cnt = 0;

  logic [16:0] wq[$];
  int kes_n, kes_cyc, cor_n, cor_cyc, sop_n;
  logic kes_b, cor_b;

  localparam logic [24:0] RESET_VEC = {1'b1, 24'd0};

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (buf_wr) wq.push_back({buf_waddr, buf_wdata});
      if (kes_start) begin kes_n++; kes_cyc = cyc; kes_b = kes_bank; end
      if (cor_start) begin cor_n++; cor_cyc = cyc; cor_b = cor_bank; end
      if (sop_err) sop_n++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rec();
    wq.delete();
    kes_n = 0; kes_cyc = 0; kes_b = 1'b0;
    cor_n = 0; cor_cyc = 0; cor_b = 1'b0;
    sop_n = 0;
    stall_cnt = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_sop = 1'b0; in_data = 8'd0;
    kes_done = 1'b0; cor_done = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
    clear_rec();
  endtask

  task automatic send(input logic sop, input logic [7:0] d);
    in_valid = 1'b1; in_sop = sop; in_data = d;
    if (!in_ready) stall_cnt++;
    step();
    in_valid = 1'b0; in_sop = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] seed);
    for (int i = 0; i < 255; i++) send(i == 0, seed + 8'(i));
  endtask

  function automatic logic [24:0] out_vec();
    return {in_ready, buf_wr, buf_waddr, buf_wdata, kes_start, kes_bank,
            cor_start, cor_bank, sop_err, proto_err};
  endfunction

  // Reset values, one full frame, write addresses and KES issue latency.
  task automatic test_reset_and_frame();
    int la, bad, first;
    logic [16:0] exp_e;
    do_reset();
    n_vec++;
    if (out_vec() !== RESET_VEC) begin
      n_bad++; $display("FAIL reset_outputs: got %h expected %h", out_vec(), RESET_VEC);
    end
    send_frame(8'h10);
    la = cyc;
    n_vec++;
    if (stall_cnt !== 0) begin n_bad++; $display("FAIL frame1_stalls: got %0d expected 0", stall_cnt); end
    repeat (3) step();
    n_vec++;
    if (wq.size() !== 255) begin n_bad++; $display("FAIL frame1_writes: got %0d expected 255", wq.size()); end
    bad = 0; first = -1;
    for (int i = 0; i < wq.size() && i < 255; i++) begin
      exp_e = {9'(i), 8'h10 + 8'(i)};
      if (wq[i] !== exp_e) begin bad++; if (first < 0) first = i; end
    end
    n_vec++;
    if (bad !== 0) begin
      n_bad++; $display("FAIL frame1_addr_data: %0d bad entries, first at %0d got %h", bad, first, wq[first]);
    end
    n_vec++;
    if (kes_n !== 1 || kes_b !== 1'b0) begin
      n_bad++; $display("FAIL frame1_kes_start: got count %0d bank %0d expected 1 bank 0", kes_n, kes_b);
    end
    n_vec++;
    if (kes_cyc !== la + 1) begin
      n_bad++; $display("FAIL frame1_kes_latency: got cycle %0d expected %0d", kes_cyc, la + 1);
    end
    n_vec++;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL frame1_ready: got %b expected 1", in_ready); end
  endtask

  // Frames A, B, C back to back with KES/correction withheld.
  task automatic test_back_to_back();
    do_reset();
    send_frame(8'h20);
    send_frame(8'h40);
    n_vec++;
    if (stall_cnt !== 0) begin n_bad++; $display("FAIL b2b_ab_stalls: got %0d expected 0", stall_cnt); end
    n_vec++;
    if (in_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_ready_drop: got %b expected 0", in_ready); end
    in_valid = 1'b1; in_sop = 1'b1; in_data = 8'hC0;
    repeat (5) step();
    n_vec++;
    if (wq.size() !== 510 || in_ready !== 1'b0) begin
      n_bad++; $display("FAIL b2b_c_stalled: got writes %0d ready %b expected 510 0", wq.size(), in_ready);
    end
    n_vec++;
    if (wq[255] !== {9'h100, 8'h40}) begin
      n_bad++; $display("FAIL b2b_b_first: got %h expected %h", wq[255], {9'h100, 8'h40});
    end
    kes_done = 1'b1; step(); kes_done = 1'b0;
    repeat (3) step();
    n_vec++;
    if (cor_n !== 1 || cor_b !== 1'b0 || kes_n !== 2 || kes_b !== 1'b1) begin
      n_bad++; $display("FAIL b2b_starts: got cor %0d/%0d kes %0d/%0d expected 1/0 2/1", cor_n, cor_b, kes_n, kes_b);
    end
    n_vec++;
    if (in_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_still_stalled: got %b expected 0", in_ready); end
    cor_done = 1'b1; step(); cor_done = 1'b0;
    n_vec++;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_rise: got %b expected 1", in_ready); end
    step();
    in_valid = 1'b0; in_sop = 1'b0;
    step();
    n_vec++;
    if (wq.size() !== 511 || wq[510] !== {9'h000, 8'hC0}) begin
      n_bad++; $display("FAIL b2b_c_write: got %0d entries last %h expected 511 %h", wq.size(), wq[wq.size()-1], {9'h000, 8'hC0});
    end
    n_vec++;
    if (proto_err !== 1'b0) begin n_bad++; $display("FAIL b2b_proto: got %b expected 0", proto_err); end
  endtask

  // Early sop restarts the frame at index 0.
  task automatic test_sop_restart();
    do_reset();
    for (int i = 0; i < 100; i++) send(i == 0, 8'(i));
    send(1'b1, 8'hAA);
    for (int i = 1; i < 255; i++) send(1'b0, 8'(i));
    repeat (3) step();
    n_vec++;
    if (sop_n !== 1) begin n_bad++; $display("FAIL restart_sop_err: got %0d expected 1", sop_n); end
    n_vec++;
    if (wq.size() !== 355) begin n_bad++; $display("FAIL restart_writes: got %0d expected 355", wq.size()); end
    n_vec++;
    if (wq[99] !== {9'h063, 8'h63} || wq[100] !== {9'h000, 8'hAA}) begin
      n_bad++; $display("FAIL restart_index0: got %h %h expected %h %h", wq[99], wq[100], {9'h063, 8'h63}, {9'h000, 8'hAA});
    end
    n_vec++;
    if (wq[354] !== {9'h0FE, 8'hFE}) begin
      n_bad++; $display("FAIL restart_last: got %h expected %h", wq[354], {9'h0FE, 8'hFE});
    end
    n_vec++;
    if (kes_n !== 1 || kes_b !== 1'b0) begin
      n_bad++; $display("FAIL restart_kes: got count %0d bank %0d expected 1 bank 0", kes_n, kes_b);
    end
  endtask

  // Symbols without sop while the bank is empty are dropped.
  task automatic test_no_sop();
    do_reset();
    send(1'b0, 8'h01);
    send(1'b0, 8'h02);
    send(1'b0, 8'h03);
    repeat (2) step();
    n_vec++;
    if (wq.size() !== 0) begin n_bad++; $display("FAIL nosop_writes: got %0d expected 0", wq.size()); end
    n_vec++;
    if (sop_n !== 3) begin n_bad++; $display("FAIL nosop_sop_err: got %0d expected 3", sop_n); end
    n_vec++;
    if (in_ready !== 1'b1 || stall_cnt !== 0) begin
      n_bad++; $display("FAIL nosop_ready: got %b stalls %0d expected 1 0", in_ready, stall_cnt);
    end
  endtask

  // kes_done(bank1) together with cor_done(bank0).
  task automatic test_simultaneous();
    int d;
    do_reset();
    send_frame(8'h00);
    send_frame(8'h80);
    step();
    kes_done = 1'b1; step(); kes_done = 1'b0;
    repeat (3) step();
    kes_n = 0; cor_n = 0;
    kes_done = 1'b1; cor_done = 1'b1;
    step();
    d = cyc;
    kes_done = 1'b0; cor_done = 1'b0;
    n_vec++;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL simul_bank0_empty: got ready %b expected 1", in_ready); end
    repeat (3) step();
    n_vec++;
    if (cor_n !== 1 || cor_b !== 1'b1) begin
      n_bad++; $display("FAIL simul_cor_start: got count %0d bank %0d expected 1 bank 1", cor_n, cor_b);
    end
    n_vec++;
    if (cor_cyc !== d + 1) begin
      n_bad++; $display("FAIL simul_cor_timing: got cycle %0d expected %0d", cor_cyc, d + 1);
    end
    n_vec++;
    if (kes_n !== 0 || proto_err !== 1'b0) begin
      n_bad++; $display("FAIL simul_no_side_effects: got kes %0d proto %b expected 0 0", kes_n, proto_err);
    end
  endtask

  // Protocol error while idle, then reset in the middle of a fill.
  task automatic test_proto_and_reset();
    do_reset();
    kes_done = 1'b1; step(); kes_done = 1'b0;
    n_vec++;
    if (proto_err !== 1'b1 || in_ready !== 1'b1) begin
      n_bad++; $display("FAIL proto_set: got proto %b ready %b expected 1 1", proto_err, in_ready);
    end
    repeat (3) step();
    n_vec++;
    if (proto_err !== 1'b1 || kes_n !== 0 || cor_n !== 0) begin
      n_bad++; $display("FAIL proto_sticky: got proto %b kes %0d cor %0d expected 1 0 0", proto_err, kes_n, cor_n);
    end
    for (int i = 0; i < 10; i++) send(i == 0, 8'h11 + 8'(i));
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (out_vec() !== RESET_VEC) begin
      n_bad++; $display("FAIL midreset_outputs: got %h expected %h", out_vec(), RESET_VEC);
    end
    step();
    rst_n = 1'b1;
    step();
    clear_rec();
    send(1'b1, 8'h77);
    repeat (3) step();
    n_vec++;
    if (wq.size() !== 1 || wq[0] !== {9'h000, 8'h77}) begin
      n_bad++; $display("FAIL midreset_restart: got %0d entries first %h expected 1 %h", wq.size(), wq[0], {9'h000, 8'h77});
    end
    n_vec++;
    if (kes_n !== 0 || cor_n !== 0 || proto_err !== 1'b0) begin
      n_bad++; $display("FAIL midreset_quiet: got kes %0d cor %0d proto %b expected 0 0 0", kes_n, cor_n, proto_err);
    end
  endtask

  initial begin
    clear_rec();
    test_reset_and_frame();
    test_back_to_back();
    test_sop_restart();
    test_no_sop();
    test_simultaneous();
    test_proto_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
